cpu_mem_bridge: RTL and testbench
=================================

# cpu_mem_bridge

Registered request bridge between the CPU memory stage and the memory controller's CPU read/write port. It latches one load/store, holds it on the controller port until `cpu_rw_vld`, stalls the CPU pipeline for the duration, and returns read data. A wait-cycle timeout guarantees the pipeline never hangs.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 255, max REQ cycles before abort; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_addr`  in  ADDR_W  memory-stage address.
- `cpu_wr_data`  in  DATA_W  store data.
- `cpu_rd`  in  1  load request; level, held while stalled.
- `cpu_wr`  in  1  store request; level, held while stalled.
- `cpu_rd_data`  out  DATA_W  load result; valid only in DONE.
- `cpu_stall`  out  1  freeze pipeline.
- `cpu_err`  out  1  one-cycle pulse in DONE when the request timed out.
- `mc_rw_addr`  out  ADDR_W  registered request address.
- `mc_rw`  out  2  {request valid, 1=read/0=write}.
- `mc_wr_data`  out  DATA_W  registered store data.
- `mc_wr_oe`  out  1  store-data drive enable for the shared `cpu_rw_data` bus.
- `mc_rd_data`  in  DATA_W  load data from controller.
- `mc_rw_vld`  in  1  controller completion strobe.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, `cpu_rd|cpu_wr` high: latch addr, wr_data, `is_wr = cpu_wr`; clear wait counter; go to REQ.
- Both `cpu_rd` and `cpu_wr` high: treated as a write. No error is raised.
- REQ: `mc_rw = {1'b1, ~is_wr}`; `mc_wr_oe = is_wr`; wait counter increments each cycle.
  - `mc_rw_vld` seen: capture `mc_rd_data` into the data register (only if read); go to DONE.
  - Counter reaches TIMEOUT without vld: data register = 0, set err flag; go to DONE.
- DONE: `cpu_stall = 0`, `cpu_rd_data` = data register, `cpu_err` = err flag. Next state IDLE unconditionally, which prevents re-issuing the held request.
- `cpu_stall = ~rst & ((IDLE & (cpu_rd|cpu_wr)) | REQ)`. Combinational in IDLE so the first cycle of a request stalls.
- Idle encoding: `mc_rw = 2'b01` in IDLE and DONE (valid low). `mc_rw_vld` outside REQ is ignored, including late strobes after a timeout.
- Wait counter width is `$clog2(TIMEOUT+1)` and saturates; it never wraps.

## Timing
- Reset (next edge with `rst` high): state IDLE, `mc_rw = 2'b01`, `mc_rw_addr = 0`, `mc_wr_data = 0`, `mc_wr_oe = 0`, data register 0, `cpu_rd_data = 0`, `cpu_err = 0`, counter 0. `cpu_stall = 0` while `rst` is high.
- Reset mid-REQ aborts the request. The controller sees valid drop on the next edge, and no data or error is reported.
- Request seen in cycle 0 → `mc_rw` valid from cycle 1 → vld in cycle k (k≥1) → DONE in cycle k+1.
- Stall is high for cycles 0..k and low in cycle k+1. Minimum is 2 stall cycles.
- Back-to-back accesses: DONE → IDLE costs one cycle, then the next request is accepted in IDLE.
- Timeout: vld never arrives → DONE in cycle TIMEOUT+1, with `cpu_err` high in that cycle only.
- All `mc_*` outputs are registered; only `cpu_stall` has a combinational path (from `cpu_rd`/`cpu_wr`).

## Structure
- Package `cpu_mem_pkg`:
  - `typedef enum logic [1:0] {IDLE, REQ, DONE} bridge_state_t`.
  - Constants `MC_NOP = 2'b01`, `MC_RD = 2'b11`, `MC_WR = 2'b10`.
  - `TIMEOUT_DEFAULT = 255`.
- One natural sub-module: `wait_timer` (saturating counter with clear/enable and `expired` output). Everything else is flat.
- Tristating of `cpu_rw_data` stays at top level using `mc_wr_oe`; the bridge has no inout ports.

## Test plan
- Read at 0x0000_0040, vld with data 0xCAFE_F00D three cycles after `mc_rw = 2'b11` → stall high 4 cycles, then `cpu_rd_data = 0xCAFE_F00D` for one cycle with `cpu_err = 0`.
- Write 0x1234_5678 to 0x0000_0100, vld after 1 cycle → `mc_rw = 2'b10`, `mc_wr_oe = 1`, `mc_wr_data = 0x1234_5678` during REQ; stall exactly 2 cycles.
- Two consecutive reads (held `cpu_rd`, address changes when stall drops) → exactly two controller requests, separated by one `mc_rw = 2'b01` DONE cycle plus one IDLE cycle.
- TIMEOUT = 4, vld never asserted → DONE 5 cycles after `mc_rw` goes valid, `cpu_err` pulses once, `cpu_rd_data = 0`. A late vld afterwards is ignored.
- `cpu_rd` and `cpu_wr` both high → write issued (`mc_rw = 2'b10`).
- `rst` high in 2nd REQ cycle → next edge: IDLE, `mc_rw = 2'b01`, all outputs zero, no `cpu_err`.

Source files
------------

// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types and constants for the CPU <-> memory-controller request bridge.
package cpu_mem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} bridge_state_t;

    // mc_rw encoding: {valid, 1=read/0=write}
    localparam logic [1:0] MC_NOP = 2'b01;
    localparam logic [1:0] MC_RD  = 2'b11;
    localparam logic [1:0] MC_WR  = 2'b10;

    localparam int TIMEOUT_DEFAULT = 255;

    function automatic logic [1:0] mc_cmd(input logic is_wr);
        return is_wr ? MC_WR : MC_RD;
    endfunction

endpackage

// File: rtl/cpu_mem_bridge_if.sv
// Memory-controller CPU read/write port; the bridge drives it as master.
interface cpu_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mc_rw_addr;
    logic [1:0]        mc_rw;
    logic [DATA_W-1:0] mc_wr_data;
    logic              mc_wr_oe;
    logic [DATA_W-1:0] mc_rd_data;
    logic              mc_rw_vld;

    modport master (
        output mc_rw_addr, mc_rw, mc_wr_data, mc_wr_oe,
        input  mc_rd_data, mc_rw_vld
    );

    modport slave (
        input  mc_rw_addr, mc_rw, mc_wr_data, mc_wr_oe,
        output mc_rd_data, mc_rw_vld
    );
endinterface

// File: rtl/cpu_mem_bridge_wait_timer.sv
// Saturating wait counter; expired flags the last permitted REQ cycle.
module wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && cnt != MAX)
            cnt <= cnt + 1'b1;
    end

    // Counter holds (TIMEOUT-1) during the TIMEOUT-th REQ cycle, so abort lands there.
    assign expired = (cnt >= LAST);
endmodule

// File: rtl/cpu_mem_bridge.sv
// Registered load/store bridge: holds one request on the controller port,
// stalls the CPU meanwhile and aborts after TIMEOUT wait cycles.
module cpu_mem_bridge
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_stall,
    output logic              cpu_err,
    cpu_mem_bridge_if.master  mc
);
    bridge_state_t     state_q, state_d;
    logic              req;
    logic              is_wr;
    logic              err_q;
    logic [DATA_W-1:0] data_q;
    logic              tmr_clr, tmr_en, tmr_expired;

    assign req = cpu_rd | cpu_wr;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                state_d = REQ;
                tmr_clr = 1'b1;
            end
            REQ: begin
                tmr_en = 1'b1;
                if (mc.mc_rw_vld || tmr_expired) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller-side registers; a simultaneous vld wins over expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc.mc_rw_addr <= '0;
            mc.mc_wr_data <= '0;
            mc.mc_rw      <= MC_NOP;
            mc.mc_wr_oe   <= 1'b0;
            is_wr         <= 1'b0;
            err_q         <= 1'b0;
            data_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    mc.mc_rw_addr <= cpu_addr;
                    mc.mc_wr_data <= cpu_wr_data;
                    mc.mc_rw      <= mc_cmd(cpu_wr);
                    mc.mc_wr_oe   <= cpu_wr;
                    is_wr         <= cpu_wr;
                    err_q         <= 1'b0;
                end
                REQ: begin
                    if (mc.mc_rw_vld) begin
                        if (!is_wr) data_q <= mc.mc_rd_data;
                        mc.mc_rw    <= MC_NOP;
                        mc.mc_wr_oe <= 1'b0;
                    end else if (tmr_expired) begin
                        data_q      <= '0;
                        err_q       <= 1'b1;
                        mc.mc_rw    <= MC_NOP;
                        mc.mc_wr_oe <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // First request cycle stalls combinationally, before the FSM has moved.
    assign cpu_stall   = ~rst & (((state_q == IDLE) & req) | (state_q == REQ));
    assign cpu_rd_data = (state_q == DONE) ? data_q : '0;
    assign cpu_err     = (state_q == DONE) & err_q;
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Scoreboard bench: stimulus queues expected controller requests and CPU
// completions; a negedge monitor pops and compares them.
module tb_cpu_mem_bridge;
    localparam int TMO = 4;

    typedef struct {
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        oe;
        int          cyc;
        int          gap;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        err;
        int          stall;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wr_data, cpu_rd_data;
    logic        cpu_rd, cpu_wr, cpu_stall, cpu_err;

    req_t  req_q[$];
    resp_t resp_q[$];
    int    errors = 0;
    int    checks = 0;

    cpu_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) mc_if ();

    cpu_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_rd_data (cpu_rd_data),
        .cpu_stall   (cpu_stall),
        .cpu_err     (cpu_err),
        .mc          (mc_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic  prev_v = 1'b0, prev_stall = 1'b0;
    int    vcnt = 0, gap_cnt = 0, scnt = 0;
    req_t  cur;
    resp_t rs;

    always @(negedge clk) begin
        if (mc_if.mc_rw[1] && !prev_v) begin
            if (req_q.size() == 0) begin
                chk("unexpected_mc_req", 1'b1, 1'b0);
            end else begin
                cur = req_q.pop_front();
                chk("mc_rw", mc_if.mc_rw, cur.rw);
                chk("mc_rw_addr", mc_if.mc_rw_addr, cur.addr);
                chk("mc_wr_oe", mc_if.mc_wr_oe, cur.oe);
                if (cur.oe) chk("mc_wr_data", mc_if.mc_wr_data, cur.wdata);
                if (cur.gap >= 0) chk("req_gap", gap_cnt, cur.gap);
            end
            vcnt = 0;
        end
        if (mc_if.mc_rw[1]) begin
            vcnt++;
        end else begin
            if (prev_v) begin
                chk("req_cycles", vcnt, cur.cyc);
                gap_cnt = 0;
            end
            gap_cnt++;
            chk("idle_enc", {mc_if.mc_rw, mc_if.mc_wr_oe}, 3'b010);
        end
        prev_v = mc_if.mc_rw[1];

        if (rst) begin
            prev_stall = 1'b0;
            scnt = 0;
        end else begin
            if (cpu_stall) scnt++;
            if (prev_stall && !cpu_stall) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    rs = resp_q.pop_front();
                    chk("stall_cycles", scnt, rs.stall);
                    chk("cpu_err", cpu_err, rs.err);
                    if (rs.chk_data) chk("cpu_rd_data", cpu_rd_data, rs.data);
                end
                scnt = 0;
            end else begin
                chk("err_quiet", cpu_err, 1'b0);
            end
            prev_stall = cpu_stall;
        end
    end

    // ---------------- stimulus ----------------
    // Entered at #1 after a posedge with the bridge in IDLE; k = REQ cycle of vld, 0 = never.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                          input bit hold, input bit late, input int gap);
        req_t  r;
        resp_t s;
        r.rw = wr ? 2'b10 : 2'b11;
        r.addr = addr; r.wdata = wdata; r.oe = wr;
        r.cyc = (k == 0) ? TMO : k;
        r.gap = gap;
        s.data = (k == 0) ? 32'h0 : rdata;
        s.chk_data = !wr;
        s.err = (k == 0);
        s.stall = r.cyc + 1;
        req_q.push_back(r);
        resp_q.push_back(s);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wr_data = wdata;
        @(posedge clk); #1;
        if (k > 0) begin
            repeat (k - 1) begin @(posedge clk); #1; end
            mc_if.mc_rw_vld = 1'b1;
            mc_if.mc_rd_data = rdata;
            @(posedge clk); #1;
            mc_if.mc_rw_vld = 1'b0;
            mc_if.mc_rd_data = $urandom;
        end else begin
            repeat (TMO) begin @(posedge clk); #1; end
        end
        if (!hold) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
        if (late) mc_if.mc_rw_vld = 1'b1;
        @(posedge clk); #1;
        if (late) begin
            @(posedge clk); #1;
            mc_if.mc_rw_vld = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wr_data = 32'h0;
        mc_if.mc_rw_vld = 1'b0; mc_if.mc_rd_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_mc_rw", mc_if.mc_rw, 2'b01);
        chk("rst_addr", mc_if.mc_rw_addr, 32'h0);
        chk("rst_wdata", mc_if.mc_wr_data, 32'h0);
        chk("rst_oe", mc_if.mc_wr_oe, 1'b0);
        chk("rst_rd_data", cpu_rd_data, 32'h0);
        chk("rst_err", cpu_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; cpu_rd = 1'b0;
        @(posedge clk); #1;

        access(1, 0, 32'h0000_0040, 32'h0, 3, 32'hCAFE_F00D, 0, 0, -1);
        access(0, 1, 32'h0000_0100, 32'h1234_5678, 1, 32'h5555_AAAA, 0, 0, -1);
        access(1, 0, 32'h0000_0200, 32'h0, 2, 32'h1111_2222, 1, 0, -1);
        access(1, 0, 32'h0000_0204, 32'h0, 1, 32'h3333_4444, 0, 0, 2);
        access(1, 0, 32'h0000_0300, 32'h0, 0, 32'h0, 0, 1, -1);
        access(1, 0, 32'h0000_0304, 32'h0, 2, 32'hA5A5_5A5A, 0, 0, -1);
        access(1, 1, 32'h0000_0400, 32'hDEAD_BEEF, 2, 32'h0, 0, 0, -1);

        // Reset during the second REQ cycle: request dropped, no completion reported.
        begin
            req_t r;
            r.rw = 2'b11; r.addr = 32'h0000_0500; r.wdata = 32'h0; r.oe = 1'b0;
            r.cyc = 2; r.gap = -1;
            req_q.push_back(r);
        end
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
        chk("rrst_mc_rw", mc_if.mc_rw, 2'b01);
        chk("rrst_addr", mc_if.mc_rw_addr, 32'h0);
        chk("rrst_oe", mc_if.mc_wr_oe, 1'b0);
        chk("rrst_rd_data", cpu_rd_data, 32'h0);
        chk("rrst_err", cpu_err, 1'b0);
        chk("rrst_stall", cpu_stall, 1'b0);

        for (int i = 0; i < 50 && (req_q.size() != 0 || resp_q.size() != 0); i++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        chk("req_q_drained", req_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
